// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART loopback FIFO slice: drain FSM encoding,
// default geometry and the pattern seed shared with the data generator.
package uart_fifo_pkg;

    localparam int         FIFO_DEPTH   = 256;
    localparam int         FIFO_DATA_W  = 8;
    localparam logic [7:0] PATTERN_SEED = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/fifo_drain_check_if.sv
// FIFO read-port bundle between the drain checker (master) and the FIFO (slave).
interface fifo_drain_check_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en
    );
endinterface

// File: rtl/drain_pattern_gen.sv
// Expected-byte counter: load restarts at SEED, advance steps by one modulo 2^DATA_W,
// tracking the data generator's incrementing sequence.
module drain_pattern_gen
    import uart_fifo_pkg::*;
#(
    parameter int                DATA_W = FIFO_DATA_W,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(PATTERN_SEED)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic              adv_i,
    output logic [DATA_W-1:0] expected_o
);

    logic [DATA_W-1:0] expected_q;
    logic [DATA_W-1:0] expected_d;

    always_comb begin
        expected_d = expected_q;
        if (load_i) begin
            expected_d = SEED;
        end else if (adv_i) begin
            expected_d = expected_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            expected_q <= SEED;
        end else begin
            expected_q <= expected_d;
        end
    end

    assign expected_o = expected_q;

endmodule

// File: rtl/fifo_drain_check.sv
// Drains DEPTH bytes from the loopback FIFO and checks them against the incrementing pattern.
// Optional empty-FIFO watchdog is built when DRAIN_CHECK_TIMEOUT_EN is defined.
module fifo_drain_check
    import uart_fifo_pkg::*;
#(
    parameter int                DATA_W = FIFO_DATA_W,
    parameter int                DEPTH  = FIFO_DEPTH,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(PATTERN_SEED)
`ifdef DRAIN_CHECK_TIMEOUT_EN
    ,
    parameter int unsigned       TIMEOUT_CYC = 1_000_000
`endif
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      start,
    fifo_drain_check_if.master        fifo,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [$clog2(DEPTH):0]    err_cnt,
    output logic [$clog2(DEPTH)-1:0]  first_err_idx,
    output logic [$clog2(DEPTH):0]    byte_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);

    drain_state_e      state_q;
    logic [CW-1:0]     issued_q;
    logic [CW-1:0]     byte_cnt_q;
    logic [CW-1:0]     err_cnt_q;
    logic [CW-1:0]     err_cnt_d;
    logic [IW-1:0]     first_err_q;
    logic              rd_vld_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              rd_en;
    logic              accept;
    logic              mismatch;
    logic              trip;
    logic [DATA_W-1:0] expected;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    // Combinational on fifo_empty so a read is never issued against an empty FIFO.
    assign rd_en = (state_q == DRAIN) && !fifo.fifo_empty && (issued_q < CW'(DEPTH));
    assign fifo.fifo_rd_en = rd_en;

    assign mismatch  = rd_vld_q && (fifo.fifo_dout != expected);
    assign err_cnt_d = err_cnt_q + CW'(mismatch);

    drain_pattern_gen #(
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_pattern (
        .clk_i      (sys_clk),
        .rst_n_i    (sys_rst_n),
        .load_i     (accept),
        .adv_i      (rd_vld_q),
        .expected_o (expected)
    );

`ifdef DRAIN_CHECK_TIMEOUT_EN
    logic [31:0] wdog_q;
    logic        timeout_q;

    // In DRAIN a cycle without a read is always an empty-FIFO cycle.
    assign trip = (state_q == DRAIN) && !rd_en && (wdog_q == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                timeout_q <= 1'b0;
            end else if (trip) begin
                timeout_q <= 1'b1;
            end
            if ((state_q != DRAIN) || rd_en) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= wdog_q + 32'd1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign trip    = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            issued_q    <= '0;
            byte_cnt_q  <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            rd_vld_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            rd_vld_q <= rd_en;

            if (rd_vld_q) begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
                err_cnt_q  <= err_cnt_d;
                if (mismatch && (err_cnt_q == '0)) begin
                    first_err_q <= byte_cnt_q[IW-1:0];
                end
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        issued_q    <= '0;
                        byte_cnt_q  <= '0;
                        err_cnt_q   <= '0;
                        first_err_q <= '0;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_en) begin
                        issued_q <= issued_q + 1'b1;
                    end
                    if (trip) begin
                        state_q <= FLUSH;
                    end else if (rd_en && (issued_q == CW'(DEPTH - 1))) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Reads stop on entry, so at most one compare is still in flight: this one.
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (err_cnt_d == '0) && !timeout;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_q;
    assign byte_cnt      = byte_cnt_q;

endmodule

// File: tb/tb_fifo_drain_check.sv
// Bench for fifo_drain_check: a queue-backed FIFO, a run-level reference model
// checked every cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_fifo_drain_check;

    localparam int         DW    = 8;
    localparam int         DEPTH = 256;
    localparam logic [7:0] SEED  = 8'h00;
`ifdef DRAIN_CHECK_TIMEOUT_EN
    localparam int         TO    = 100;
`endif

    logic       clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass, timeout;
    logic [8:0] err_cnt, byte_cnt;
    logic [7:0] first_err_idx;

    fifo_drain_check_if #(.DATA_W(DW)) fif ();

    fifo_drain_check #(
        .DATA_W      (DW),
        .DEPTH       (DEPTH),
        .SEED        (SEED)
`ifdef DRAIN_CHECK_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (TO)
`endif
    ) dut (
        .sys_clk       (clk),
        .sys_rst_n     (sys_rst_n),
        .start         (start),
        .fifo          (fif),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .byte_cnt      (byte_cnt)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] fq[$];
    bit         rd_seen = 1'b0;
    bit         start_next = 1'b0;
    int         rd_total = 0;
    int         trickle_left = 0;
    logic [7:0] trickle_val = 8'h00;
    int         tick = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference model: a run is a start cycle, a list of read cycles/bytes and an end cycle.
    task automatic compare_loop();
        int         mcyc;
        bit         m_run;
        int         m_ts;
        int         m_end;
        bit         m_to;
        int         m_streak;
        int         m_rcyc[$];
        logic [7:0] m_got[$];
        int         bc, ec, fe;
        bit         dn, bz, drn, erd;
        mcyc = 0; m_run = 0; m_ts = 0; m_end = -1; m_to = 0; m_streak = 0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (!sys_rst_n) begin
                m_run = 0; m_end = -1; m_to = 0; m_streak = 0;
                m_rcyc.delete(); m_got.delete();
            end else begin
                bc = 0;
                foreach (m_rcyc[i]) if (m_rcyc[i] <= mcyc - 2) bc++;
                ec = 0; fe = 0;
                for (int i = 0; i < bc; i++) begin
                    if (m_got[i] != 8'(SEED + i)) begin
                        if (ec == 0) fe = i;
                        ec++;
                    end
                end
                dn  = m_run && (m_end >= 0) && (mcyc >= m_end + 2);
                bz  = m_run && (mcyc >= m_ts + 1) && !dn;
                drn = m_run && (mcyc >= m_ts + 1) && (m_end < 0);
                erd = drn && !fif.fifo_empty && (m_rcyc.size() < DEPTH);
                chk("m_rd_en", 32'(fif.fifo_rd_en), 32'(erd));
                chk("m_busy", 32'(busy), 32'(bz));
                chk("m_done", 32'(done), 32'(dn));
                chk("m_byte_cnt", 32'(byte_cnt), 32'(bc));
                chk("m_err_cnt", 32'(err_cnt), 32'(ec));
                if (dn) begin
                    chk("m_pass", 32'(pass), 32'((ec == 0) && !m_to));
                    chk("m_timeout", 32'(timeout), 32'(m_to));
                    chk("m_first_err", 32'(first_err_idx), 32'(fe));
                end
                if (erd) begin
                    m_rcyc.push_back(mcyc);
                    m_got.push_back((fq.size() > 0) ? fq[0] : 8'h00);
                    if (m_rcyc.size() == DEPTH) m_end = mcyc;
                end
`ifdef DRAIN_CHECK_TIMEOUT_EN
                if (drn && !erd) begin
                    m_streak++;
                    if (m_streak == TO) begin
                        m_end = mcyc;
                        m_to  = 1;
                    end
                end else begin
                    m_streak = 0;
                end
`endif
                if (start && (!m_run || dn)) begin
                    m_run = 1; m_ts = mcyc; m_end = -1; m_to = 0; m_streak = 0;
                    m_rcyc.delete(); m_got.delete();
                end
            end
        end
    endtask

    // One clock: FIFO pop/push and input changes 1ns after the edge, read strobe sampled at negedge.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (rd_seen && (fq.size() > 0)) fif.fifo_dout = fq.pop_front();
        if (trickle_left > 0) begin
            if (tick == 0) begin
                fq.push_back(trickle_val);
                trickle_val++;
                trickle_left--;
                tick = 4;
            end else begin
                tick--;
            end
        end
        fif.fifo_empty = (fq.size() == 0);
        start = start_next;
        start_next = 1'b0;
        @(negedge clk);
        rd_seen = fif.fifo_rd_en;
        if (rd_seen) rd_total++;
    endtask

    task automatic fill(input int n, input int ia, input logic [7:0] va, input int ib, input logic [7:0] vb);
        for (int i = 0; i < n; i++) begin
            if (i == ia) fq.push_back(va);
            else if (i == ib) fq.push_back(vb);
            else fq.push_back(8'(SEED + i));
        end
    endtask

    task automatic kick();
        rd_total = 0;
        start_next = 1'b1;
        cycle();
    endtask

    task automatic run_to_done(output int lat, output int gap);
        int last;
        bit ok;
        lat = 0; last = 0; ok = 0;
        for (int n = 1; n <= 3000 && !ok; n++) begin
            cycle();
            if (rd_seen) last = n;
            if (done) begin
                ok = 1;
                lat = n;
            end
        end
        if (!ok) chk("done_wait", 32'(done), 32'd1);
        gap = lat - last;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
        chk({tag, "_first_err"}, 32'(first_err_idx), 0);
        chk({tag, "_byte_cnt"}, 32'(byte_cnt), 0);
        chk({tag, "_rd_en"}, 32'(fif.fifo_rd_en), 0);
    endtask

    initial begin
        int lat, gap;
        bit hit;
        fif.fifo_empty = 1'b1;
        fif.fifo_dout  = '0;
        fork
            compare_loop();
        join_none

        #1;
        check_all_zero("rst");
        repeat (3) cycle();
        sys_rst_n = 1'b1;
        cycle();

        // Full prefill of the incrementing pattern
        fill(256, -1, 8'h00, -1, 8'h00);
        kick();
        run_to_done(lat, gap);
        chk("t1_done_lat", 32'(lat), 258);
        chk("t1_rd_pulses", 32'(rd_total), 256);
        chk("t1_pass", 32'(pass), 1);
        chk("t1_err_cnt", 32'(err_cnt), 0);
        chk("t1_byte_cnt", 32'(byte_cnt), 256);
        chk("t1_timeout", 32'(timeout), 0);

        // Two corrupted bytes
        fill(256, 17, 8'hAA, 200, 8'h00);
        kick();
        run_to_done(lat, gap);
        chk("t2_pass", 32'(pass), 0);
        chk("t2_err_cnt", 32'(err_cnt), 2);
        chk("t2_first_err", 32'(first_err_idx), 17);
        chk("t2_byte_cnt", 32'(byte_cnt), 256);

        // Start from DONE with an empty FIFO: results clear, reads wait for data
        kick();
        cycle();
        chk("t6_done_clr", 32'(done), 0);
        chk("t6_busy", 32'(busy), 1);
        chk("t6_err_clr", 32'(err_cnt), 0);
        chk("t6_first_clr", 32'(first_err_idx), 0);
        repeat (5) cycle();
        chk("t6_no_read", 32'(rd_total), 0);
        fill(256, -1, 8'h00, -1, 8'h00);
        run_to_done(lat, gap);
        chk("t6_pass", 32'(pass), 1);
        chk("t6_byte_cnt", 32'(byte_cnt), 256);

        // Trickle feed: one byte every 5 cycles
        trickle_left = 256;
        trickle_val  = SEED;
        tick = 0;
        kick();
        run_to_done(lat, gap);
        chk("t3_pass", 32'(pass), 1);
        chk("t3_done_gap", 32'(gap), 2);
        chk("t3_byte_cnt", 32'(byte_cnt), 256);
        chk("t3_rd_pulses", 32'(rd_total), 256);

        // Reset in the middle of a run
        fill(256, -1, 8'h00, -1, 8'h00);
        kick();
        hit = 0;
        for (int n = 0; n < 400 && !hit; n++) begin
            cycle();
            if (byte_cnt == 9'd100) hit = 1;
        end
        chk("t4_reach_100", 32'(byte_cnt), 100);
        #1 sys_rst_n = 1'b0;
        #1;
        check_all_zero("t4_mid_rst");
        fq.delete();
        rd_seen = 1'b0;
        repeat (2) cycle();
        sys_rst_n = 1'b1;
        cycle();
        fill(256, -1, 8'h00, -1, 8'h00);
        kick();
        run_to_done(lat, gap);
        chk("t4_pass", 32'(pass), 1);
        chk("t4_done_lat", 32'(lat), 258);

        // Second start while busy is ignored
        fill(256, -1, 8'h00, -1, 8'h00);
        kick();
        repeat (40) cycle();
        start_next = 1'b1;
        run_to_done(lat, gap);
        chk("t5_done_lat", 32'(lat), 218);
        chk("t5_pass", 32'(pass), 1);
        chk("t5_byte_cnt", 32'(byte_cnt), 256);

`ifdef DRAIN_CHECK_TIMEOUT_EN
        // Ten bytes then a dry FIFO: the watchdog ends the run
        fill(10, -1, 8'h00, -1, 8'h00);
        kick();
        run_to_done(lat, gap);
        chk("t7_timeout", 32'(timeout), 1);
        chk("t7_pass", 32'(pass), 0);
        chk("t7_byte_cnt", 32'(byte_cnt), 10);
        chk("t7_done_gap", 32'(gap), 102);
`endif

        repeat (2) cycle();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
